// File: rtl/k2_pkg.sv
// Shared types for the K2 memory arbiter: FSM states and port-owner encoding.
package k2_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_B, ARB_YIELD} k2_arb_state_t;
  typedef enum logic {OWN_A, OWN_B} k2_owner_t;

endpackage

// File: rtl/k2_mem_arbiter_if.sv
// Requester A, requester B and RAM signals seen by the K2 memory arbiter.
interface k2_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_lock;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, b_lock, mem_rdata,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus RAM, i.e. everything around the arbiter.
  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, b_lock, mem_rdata,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/k2_rr_pick2.sv
// Two-way round-robin pick: bit 0 = port A, bit 1 = port B; a tie goes to
// the port that was not granted last.
module k2_rr_pick2
  import k2_pkg::*;
(
  input  logic [1:0] req,
  input  k2_owner_t  last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | (last == OWN_B));
  assign gnt[1] = req[1] & (~req[0] | (last == OWN_A));

endmodule

// File: rtl/k2_mem_arbiter.sv
// Shares the single-port K2 RAM between the CPU read path (A) and the
// loader/debug path (B), with round-robin arbitration and bounded B bursts.
module k2_mem_arbiter
  import k2_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  k2_mem_arbiter_if.slave   bus
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  k2_arb_state_t state, state_n;
  k2_owner_t     last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ga, gb, take_rr;
  logic [1:0]    rr_gnt;
  logic          rd_vld_q;
  k2_owner_t     rd_own_q;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] rdata;

  k2_rr_pick2 u_rr (
    .req  ({bus.b_req, bus.a_req}),
    .last (last),
    .gnt  (rr_gnt)
  );

  // State register, burst counter and the 1-cycle read-owner register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      last     <= OWN_B;
      cnt      <= '0;
      rd_vld_q <= 1'b0;
      rd_own_q <= OWN_A;
    end else begin
      state    <= state_n;
      last     <= last_n;
      cnt      <= cnt_n;
      rd_vld_q <= ga | (gb & ~bus.b_we);
      rd_own_q <= gb ? OWN_B : OWN_A;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    ga      = 1'b0;
    gb      = 1'b0;
    take_rr = 1'b0;
    case (state)
      ARB_IDLE: take_rr = 1'b1;
      ARB_LOCK_B: begin
        if (bus.b_req && bus.b_lock) begin
          // Saturated burst with A now waiting: hand over next cycle.
          if (cnt == MAX_CNT && bus.a_req) begin
            state_n = ARB_YIELD;
          end else begin
            gb     = 1'b1;
            last_n = OWN_B;
            if (cnt != MAX_CNT) cnt_n = cnt + ONE_CNT;
            if (cnt_n == MAX_CNT && bus.a_req) state_n = ARB_YIELD;
          end
        end else begin
          // Lock released: arbitrate normally in this same cycle.
          state_n = ARB_IDLE;
          cnt_n   = '0;
          take_rr = 1'b1;
        end
      end
      ARB_YIELD: begin
        state_n = ARB_IDLE;
        cnt_n   = '0;
        if (bus.a_req) begin
          ga     = 1'b1;
          last_n = OWN_A;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        cnt_n   = '0;
      end
    endcase

    if (take_rr) begin
      ga = rr_gnt[0];
      gb = rr_gnt[1];
      if (rr_gnt[0]) last_n = OWN_A;
      if (rr_gnt[1]) begin
        last_n = OWN_B;
        if (bus.b_lock) begin
          cnt_n   = ONE_CNT;
          state_n = (ONE_CNT == MAX_CNT && bus.a_req) ? ARB_YIELD : ARB_LOCK_B;
        end
      end
    end
  end

  assign addr_mux = gb ? bus.b_addr : bus.a_addr;
  assign rdata    = bus.mem_rdata;

  // Reset masks grants and any read still in flight in the reset cycle itself.
  always_comb begin
    bus.a_gnt     = ga & ~reset;
    bus.b_gnt     = gb & ~reset;
    bus.a_rvalid  = rd_vld_q & (rd_own_q == OWN_A) & ~reset;
    bus.b_rvalid  = rd_vld_q & (rd_own_q == OWN_B) & ~reset;
    bus.a_rdata   = rdata;
    bus.b_rdata   = rdata;
    bus.mem_en    = (ga | gb) & ~reset;
    bus.mem_we    = gb & bus.b_we & ~reset;
    bus.mem_addr  = addr_mux;
    bus.mem_wdata = bus.b_wdata;
  end

endmodule

// File: tb/tb_k2_mem_arbiter.sv
// Directed and constrained-random checks of k2_mem_arbiter against a small RAM model.
module tb_k2_mem_arbiter;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  k2_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

  k2_mem_arbiter #(.AW(8), .DW(8), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten locations read as addr ^ 8'h5A.
  logic [7:0] ram     [256];
  logic       written [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]     <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= (written[bus.mem_addr] === 1'b1) ? ram[bus.mem_addr]
                                                          : (bus.mem_addr ^ 8'h5A);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic a_g, b_g, b_rd, exp_arv, exp_brv;
  int   a_wait;

  initial begin
    reset         = 1'b1;
    bus.a_req     = 1'b1;
    bus.a_addr    = 8'h00;
    bus.b_req     = 1'b1;
    bus.b_we      = 1'b0;
    bus.b_addr    = 8'h00;
    bus.b_wdata   = 8'h00;
    bus.b_lock    = 1'b0;
    bus.mem_rdata = 8'h00;

    // Reset: requests present but everything held low.
    tick; tick; smp;
    chk("rst_a_gnt", bus.a_gnt, 0);
    chk("rst_b_gnt", bus.b_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    chk("rst_b_rvalid", bus.b_rvalid, 0);

    // 1: simultaneous first requests, A wins then B.
    tick;
    reset = 1'b0; bus.a_addr = 8'h20; bus.b_addr = 8'h33;
    smp;
    chk("t1_c1_a_gnt", bus.a_gnt, 1);
    chk("t1_c1_b_gnt", bus.b_gnt, 0);
    chk("t1_c1_addr", bus.mem_addr, 8'h20);
    tick; bus.a_req = 1'b0; smp;
    chk("t1_c2_b_gnt", bus.b_gnt, 1);
    chk("t1_c2_a_rvalid", bus.a_rvalid, 1);
    chk("t1_c2_a_rdata", bus.a_rdata, 8'h7A);
    chk("t1_c2_addr", bus.mem_addr, 8'h33);
    tick; bus.b_req = 1'b0; smp;
    chk("t1_c3_b_rvalid", bus.b_rvalid, 1);
    chk("t1_c3_b_rdata", bus.b_rdata, 8'h69);
    chk("t1_c3_a_rvalid", bus.a_rvalid, 0);
    chk("t1_c3_b_gnt", bus.b_gnt, 0);

    // 2: B write then A read-back.
    tick;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h10; bus.b_wdata = 8'hA5;
    smp;
    chk("t2_b_gnt", bus.b_gnt, 1);
    chk("t2_mem_we", bus.mem_we, 1);
    chk("t2_mem_wdata", bus.mem_wdata, 8'hA5);
    chk("t2_mem_addr", bus.mem_addr, 8'h10);
    tick;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.a_req = 1'b1; bus.a_addr = 8'h10;
    smp;
    chk("t2_no_b_rvalid", bus.b_rvalid, 0);
    chk("t2_a_gnt", bus.a_gnt, 1);
    tick; bus.a_req = 1'b0; smp;
    chk("t2_a_rvalid", bus.a_rvalid, 1);
    chk("t2_a_rdata", bus.a_rdata, 8'hA5);

    // 3: locked burst of 4 B grants, one A grant, then B relocks.
    tick;
    bus.b_req = 1'b1; bus.b_lock = 1'b1; bus.b_addr = 8'h40;
    smp;
    chk("t3_burst1", bus.b_gnt, 1);
    tick; bus.a_req = 1'b1; bus.a_addr = 8'h50;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("t3_burst_b", bus.b_gnt, 1);
      chk("t3_burst_a_stall", bus.a_gnt, 0);
      tick;
    end
    smp;
    chk("t3_yield_a_gnt", bus.a_gnt, 1);
    chk("t3_yield_b_gnt", bus.b_gnt, 0);
    tick; bus.a_req = 1'b0; smp;
    chk("t3_relock_b_gnt", bus.b_gnt, 1);

    // 4: lock held with A idle, counter saturates, then A served after one cycle.
    for (int i = 0; i < 10; i++) begin
      tick; smp;
      chk("t4_sat_b_gnt", bus.b_gnt, 1);
    end
    tick; bus.a_req = 1'b1; smp;
    chk("t4_handover_b_gnt", bus.b_gnt, 0);
    chk("t4_handover_a_gnt", bus.a_gnt, 0);
    tick; smp;
    chk("t4_a_gnt", bus.a_gnt, 1);
    tick; bus.a_req = 1'b0; bus.b_req = 1'b0; bus.b_lock = 1'b0;

    // 5: reset right after a B read grant drops its rvalid.
    bus.b_req = 1'b1; bus.b_addr = 8'h77;
    smp;
    chk("t5_b_gnt", bus.b_gnt, 1);
    tick; reset = 1'b1; bus.b_req = 1'b0; smp;
    chk("t5_b_rvalid_dropped", bus.b_rvalid, 0);
    chk("t5_rst_mem_en", bus.mem_en, 0);
    tick; reset = 1'b0; smp;
    chk("t5_post_b_rvalid", bus.b_rvalid, 0);
    chk("t5_post_a_rvalid", bus.a_rvalid, 0);
    chk("t5_post_mem_en", bus.mem_en, 0);
    // Reset must restore last_gnt=B even after A was granted last.
    tick; bus.a_req = 1'b1; smp;
    chk("t5_a_only_gnt", bus.a_gnt, 1);
    tick; bus.a_req = 1'b0; reset = 1'b1; smp;
    chk("t5_a_rvalid_dropped", bus.a_rvalid, 0);
    tick; reset = 1'b0; bus.a_req = 1'b1; bus.b_req = 1'b1; smp;
    chk("t5_tie_a_gnt", bus.a_gnt, 1);
    chk("t5_tie_b_gnt", bus.b_gnt, 0);
    tick; bus.a_req = 1'b0; smp;
    chk("t5_tie_then_b", bus.b_gnt, 1);
    tick; bus.b_req = 1'b0;

    // 6: random traffic with per-cycle invariants.
    reset = 1'b1; tick; reset = 1'b0;
    exp_arv = 1'b0; exp_brv = 1'b0; a_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      smp;
      chk("r_mutex", bus.a_gnt & bus.b_gnt, 0);
      chk("r_a_rvalid", bus.a_rvalid, exp_arv);
      chk("r_b_rvalid", bus.b_rvalid, exp_brv);
      chk("r_a_gnt_req", bus.a_gnt & ~bus.a_req, 0);
      chk("r_b_gnt_req", bus.b_gnt & ~bus.b_req, 0);
      if (bus.a_req && !bus.a_gnt) a_wait++;
      else a_wait = 0;
      chk("r_a_wait", 8'(a_wait <= MAX_BURST + 1), 1);
      a_g  = bus.a_gnt;
      b_g  = bus.b_gnt;
      b_rd = bus.b_gnt & ~bus.b_we;
      tick;
      exp_arv = a_g;
      exp_brv = b_rd;
      if (!bus.a_req || a_g) begin
        bus.a_req  = ($urandom_range(0, 2) != 0);
        bus.a_addr = 8'($urandom);
      end
      if (!bus.b_req || b_g) begin
        bus.b_req   = ($urandom_range(0, 3) != 0);
        bus.b_we    = 1'($urandom_range(0, 1));
        bus.b_addr  = 8'($urandom);
        bus.b_wdata = 8'($urandom);
      end
      bus.b_lock = ($urandom_range(0, 7) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
